// File: rtl/regbank_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : regbank_write_arbiter_if
// Brief    : Requester-side valid/ready bundle for the register-bank write port.
// Revision : 1.0 - initial release
// ============================================================================
interface regbank_write_arbiter_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]    req_valid;
    logic [4*NREQ-1:0]  req_addr;
    logic [16*NREQ-1:0] req_data;
    logic [NREQ-1:0]    req_ready;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );
endinterface
`default_nettype wire

// File: rtl/regbank_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regbank_write_arbiter
// Brief    : Round-robin arbiter sharing the register bank's single write port.
// Revision : 1.0 - initial release
// ============================================================================
module regbank_write_arbiter #(
    parameter int NREQ = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    regbank_write_arbiter_if.slave  req,
    input  logic                    stall,
    output logic [15:0]             ALUBus,
    output logic [15:0]             regEnable,
    output logic [1:0]              grant_id,
    output logic                    wb_valid
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    state_t             r_state;
    logic [1:0]         r_ptr;

    logic               w_found;
    logic [1:0]         w_win;
    logic [2:0]         w_idx;
    logic               w_accept;
    logic [1:0]         w_ptr_next;
    logic [15:0]        w_data;
    logic [3:0]         w_addr;
    logic [NREQ-1:0]    w_ready;

    // Walk indices ptr, ptr+1, ... wrapping at NREQ; first valid one wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = 2'd0;
        w_idx   = 3'd0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_ptr} + 3'(k);
            if (w_idx >= 3'(NREQ)) begin
                w_idx = w_idx - 3'(NREQ);
            end
            for (int j = 0; j < NREQ; j++) begin
                if (!w_found && (w_idx == 3'(j)) && req.req_valid[j]) begin
                    w_found = 1'b1;
                    w_win   = 2'(j);
                end
            end
        end
    end

    always_comb begin
        w_data = 16'h0000;
        w_addr = 4'h0;
        for (int j = 0; j < NREQ; j++) begin
            if (w_win == 2'(j)) begin
                w_data = req.req_data[16*j +: 16];
                w_addr = req.req_addr[4*j +: 4];
            end
        end
    end

    assign w_accept   = w_found && !stall && !reset;
    assign w_ptr_next = (w_win == 2'(NREQ - 1)) ? 2'd0 : w_win + 2'd1;

    always_comb begin
        w_ready = '0;
        for (int j = 0; j < NREQ; j++) begin
            w_ready[j] = w_accept && (w_win == 2'(j));
        end
    end

    assign req.req_ready = w_ready;

    // ALUBus and grant_id deliberately hold across idle cycles; only the enable clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_ptr     <= 2'd0;
            ALUBus    <= 16'h0000;
            regEnable <= 16'h0000;
            grant_id  <= 2'd0;
        end else if (w_accept) begin
            r_state   <= ST_WRITE;
            r_ptr     <= w_ptr_next;
            ALUBus    <= w_data;
            regEnable <= 16'h0001 << w_addr;
            grant_id  <= w_win;
        end else begin
            r_state   <= ST_IDLE;
            regEnable <= 16'h0000;
        end
    end

    assign wb_valid = (r_state == ST_WRITE);

endmodule
`default_nettype wire

// File: tb/tb_regbank_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regbank_write_arbiter
// Brief    : Scenario and randomized checks of the register-bank write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regbank_write_arbiter;

    localparam int NREQ = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [15:0] ALUBus;
    logic [15:0] regEnable;
    logic [1:0]  grant_id;
    logic        wb_valid;

    regbank_write_arbiter_if #(.NREQ(NREQ)) bus ();

    regbank_write_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (bus),
        .stall     (stall),
        .ALUBus    (ALUBus),
        .regEnable (regEnable),
        .grant_id  (grant_id),
        .wb_valid  (wb_valid)
    );

    always #5 clk = ~clk;

    // Register bank fed by the arbiter outputs
    logic [15:0] bank [16] = '{default: 16'h0000};
    always @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (regEnable[i]) bank[i] <= ALUBus;
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    int          m_ptr;
    logic [15:0] e_bus;
    logic [15:0] e_en;
    logic [1:0]  e_gid;
    logic        e_wbv;

    function automatic int exp_winner();
        if (reset || stall) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (bus.req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] ready_of(int win);
        logic [NREQ-1:0] r;
        r = '0;
        if (win >= 0) r[win] = 1'b1;
        return r;
    endfunction

    task automatic set_req(int i, logic v, logic [3:0] a, logic [15:0] d);
        bus.req_valid[i]         = v;
        bus.req_addr[4*i +: 4]   = a;
        bus.req_data[16*i +: 16] = d;
    endtask

    task automatic clear_reqs();
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
    endtask

    // Advance the model across one edge, then step the clock.
    task automatic tick(output int win);
        win = exp_winner();
        if (reset) begin
            e_bus = 16'h0000; e_en = 16'h0000; e_gid = 2'd0; e_wbv = 1'b0; m_ptr = 0;
        end else if (win >= 0) begin
            e_bus = bus.req_data[16*win +: 16];
            e_en  = 16'h0001 << bus.req_addr[4*win +: 4];
            e_gid = 2'(win);
            e_wbv = 1'b1;
            m_ptr = (win + 1) % NREQ;
        end else begin
            e_en  = 16'h0000;
            e_wbv = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int w;
        reset = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 4'(i), 16'(i + 1));
        repeat (2) begin
            #1;
            n_total++;
            if (bus.req_ready !== 3'b000) $display("FAIL reset_ready: got %b want 000", bus.req_ready);
            else n_pass++;
            tick(w);
            @(negedge clk);
        end
        reset = 1'b0;
        n_total++;
        if ({ALUBus, regEnable, grant_id, wb_valid} !== 35'h0)
            $display("FAIL reset_outputs: got bus=%h en=%h gid=%0d wbv=%b want all zero",
                     ALUBus, regEnable, grant_id, wb_valid);
        else n_pass++;
        #1;
        n_total++;
        if (bus.req_ready !== 3'b001) $display("FAIL reset_ptr: got ready=%b want 001", bus.req_ready);
        else n_pass++;
        clear_reqs();
    endtask

    task automatic test_single_write();
        int w;
        set_req(1, 1'b1, 4'd5, 16'hBEEF);
        #1;
        n_total++;
        if (bus.req_ready !== 3'b010) $display("FAIL single_ready: got %b want 010", bus.req_ready);
        else n_pass++;
        tick(w);
        n_total++;
        if ({ALUBus, regEnable, grant_id, wb_valid} !== {16'hBEEF, 16'h0020, 2'd1, 1'b1})
            $display("FAIL single_write: got bus=%h en=%h gid=%0d wbv=%b want BEEF 0020 1 1",
                     ALUBus, regEnable, grant_id, wb_valid);
        else n_pass++;
        @(negedge clk);
        clear_reqs();
        #1;
        tick(w);
        n_total++;
        if ({ALUBus, regEnable, grant_id, wb_valid} !== {16'hBEEF, 16'h0000, 2'd1, 1'b0})
            $display("FAIL single_idle: got bus=%h en=%h gid=%0d wbv=%b want BEEF 0000 1 0",
                     ALUBus, regEnable, grant_id, wb_valid);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int w;
        logic [2:0]  exp_rdy;
        logic [15:0] exp_en;
        logic [15:0] exp_dat;
        reset = 1'b1;
        clear_reqs();
        tick(w);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 4'(i + 1), 16'(16'h1111 * (i + 1)));
        for (int c = 0; c < 6; c++) begin
            exp_rdy = 3'b001 << (c % 3);
            exp_en  = 16'h0002 << (c % 3);
            exp_dat = 16'(16'h1111 * ((c % 3) + 1));
            #1;
            n_total++;
            if (bus.req_ready !== exp_rdy) $display("FAIL rr_ready[%0d]: got %b want %b", c, bus.req_ready, exp_rdy);
            else n_pass++;
            tick(w);
            n_total++;
            if ({ALUBus, regEnable, grant_id, wb_valid} !== {exp_dat, exp_en, 2'(c % 3), 1'b1})
                $display("FAIL rr_grant[%0d]: got bus=%h en=%h gid=%0d wbv=%b want %h %h %0d 1",
                         c, ALUBus, regEnable, grant_id, wb_valid, exp_dat, exp_en, c % 3);
            else n_pass++;
            @(negedge clk);
        end
        clear_reqs();
    endtask

    task automatic test_same_register();
        int w;
        set_req(1, 1'b1, 4'd0, 16'h0101);
        #1;
        tick(w);
        @(negedge clk);
        clear_reqs();
        set_req(0, 1'b1, 4'd7, 16'hAAAA);
        set_req(2, 1'b1, 4'd7, 16'h5555);
        #1;
        n_total++;
        if (bus.req_ready !== 3'b100) $display("FAIL conflict_ready: got %b want 100", bus.req_ready);
        else n_pass++;
        tick(w);
        n_total++;
        if ({ALUBus, regEnable, grant_id} !== {16'h5555, 16'h0080, 2'd2})
            $display("FAIL conflict_first: got bus=%h en=%h gid=%0d want 5555 0080 2", ALUBus, regEnable, grant_id);
        else n_pass++;
        @(negedge clk);
        bus.req_valid[2] = 1'b0;
        #1;
        tick(w);
        n_total++;
        if ({ALUBus, regEnable, grant_id} !== {16'hAAAA, 16'h0080, 2'd0})
            $display("FAIL conflict_second: got bus=%h en=%h gid=%0d want AAAA 0080 0", ALUBus, regEnable, grant_id);
        else n_pass++;
        @(negedge clk);
        clear_reqs();
        #1;
        tick(w);
        n_total++;
        if (bank[7] !== 16'hAAAA) $display("FAIL conflict_bank: got r7=%h want AAAA", bank[7]);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_stall();
        int w;
        set_req(1, 1'b1, 4'd3, 16'h3C3C);
        #1;
        tick(w);
        @(negedge clk);
        clear_reqs();
        stall = 1'b1;
        set_req(0, 1'b1, 4'd9, 16'h1234);
        set_req(1, 1'b1, 4'd10, 16'h5678);
        #1;
        n_total++;
        if ({ALUBus, regEnable} !== {16'h3C3C, 16'h0008})
            $display("FAIL stall_inflight: got bus=%h en=%h want 3C3C 0008", ALUBus, regEnable);
        else n_pass++;
        for (int s = 0; s < 3; s++) begin
            n_total++;
            if (bus.req_ready !== 3'b000) $display("FAIL stall_ready[%0d]: got %b want 000", s, bus.req_ready);
            else n_pass++;
            tick(w);
            n_total++;
            if ({regEnable, wb_valid} !== 17'h0)
                $display("FAIL stall_idle[%0d]: got en=%h wbv=%b want 0000 0", s, regEnable, wb_valid);
            else n_pass++;
            @(negedge clk);
            #1;
        end
        stall = 1'b0;
        #1;
        n_total++;
        if (bus.req_ready !== 3'b001) $display("FAIL stall_release_ready: got %b want 001", bus.req_ready);
        else n_pass++;
        tick(w);
        n_total++;
        if ({ALUBus, regEnable, grant_id, wb_valid} !== {16'h1234, 16'h0200, 2'd0, 1'b1})
            $display("FAIL stall_release: got bus=%h en=%h gid=%0d wbv=%b want 1234 0200 0 1",
                     ALUBus, regEnable, grant_id, wb_valid);
        else n_pass++;
        @(negedge clk);
        clear_reqs();
    endtask

    task automatic test_back_to_back();
        int w;
        for (int c = 0; c < 4; c++) begin
            set_req(2, 1'b1, 4'(c + 11), 16'(16'hC000 + c));
            #1;
            n_total++;
            if (bus.req_ready !== 3'b100) $display("FAIL b2b_ready[%0d]: got %b want 100", c, bus.req_ready);
            else n_pass++;
            tick(w);
            n_total++;
            if ({ALUBus, grant_id, wb_valid} !== {16'(16'hC000 + c), 2'd2, 1'b1})
                $display("FAIL b2b_grant[%0d]: got bus=%h gid=%0d wbv=%b want %h 2 1",
                         c, ALUBus, grant_id, wb_valid, 16'(16'hC000 + c));
            else n_pass++;
            @(negedge clk);
        end
        clear_reqs();
    endtask

    task automatic test_reset_mid_write();
        int w;
        set_req(1, 1'b1, 4'd4, 16'h4444);
        #1;
        n_total++;
        if (bus.req_ready !== 3'b010) $display("FAIL midrst_ready: got %b want 010", bus.req_ready);
        else n_pass++;
        tick(w);
        n_total++;
        if (regEnable !== 16'h0010) $display("FAIL midrst_accept: got en=%h want 0010", regEnable);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        bus.req_valid[1] = 1'b0;
        set_req(0, 1'b1, 4'd1, 16'h0A0A);
        set_req(2, 1'b1, 4'd2, 16'h0C0C);
        #1;
        n_total++;
        if (bus.req_ready !== 3'b000) $display("FAIL midrst_ready_low: got %b want 000", bus.req_ready);
        else n_pass++;
        tick(w);
        n_total++;
        if ({ALUBus, regEnable, wb_valid} !== 33'h0)
            $display("FAIL midrst_drop: got bus=%h en=%h wbv=%b want 0000 0000 0", ALUBus, regEnable, wb_valid);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        set_req(1, 1'b1, 4'd4, 16'h4444);
        #1;
        n_total++;
        if (bus.req_ready !== 3'b001) $display("FAIL midrst_order: got %b want 001", bus.req_ready);
        else n_pass++;
        tick(w);
        @(negedge clk);
        clear_reqs();
    endtask

    task automatic test_random();
        int w;
        logic [NREQ-1:0] exp_rdy;
        clear_reqs();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i])
                    set_req(i, ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)), 16'($urandom));
            end
            stall = ($urandom_range(0, 7) == 0);
            #1;
            exp_rdy = ready_of(exp_winner());
            n_total++;
            if (bus.req_ready !== exp_rdy) $display("FAIL rand_ready[%0d]: got %b want %b", c, bus.req_ready, exp_rdy);
            else n_pass++;
            tick(w);
            n_total++;
            if ({ALUBus, regEnable, grant_id, wb_valid} !== {e_bus, e_en, e_gid, e_wbv})
                $display("FAIL rand_out[%0d]: got bus=%h en=%h gid=%0d wbv=%b want %h %h %0d %b",
                         c, ALUBus, regEnable, grant_id, wb_valid, e_bus, e_en, e_gid, e_wbv);
            else n_pass++;
            @(negedge clk);
            if (w >= 0) bus.req_valid[w] = 1'b0;
        end
        stall = 1'b0;
        clear_reqs();
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        clear_reqs();
        m_ptr = 0;
        e_bus = 16'h0000;
        e_en  = 16'h0000;
        e_gid = 2'd0;
        e_wbv = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_write();
        test_round_robin();
        test_same_register();
        test_stall();
        test_back_to_back();
        test_reset_mid_write();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
